// File: rtl/serial_pkg.sv
// Shared definitions for the serial front end and the downstream 101 detector.
//   WIDTH_DEFAULT : default word width, also reused by the detector testbench
//   state_e       : serializer FSM states
package serial_pkg;
    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;
endpackage

// File: rtl/bit_serializer_hold_reg.sv
// hold_reg: one-entry word buffer sitting in front of the shifter.
//   clk, reset : clock, asynchronous active-low reset
//   wr, d      : capture d and mark full
//   rd         : release the stored word (marks empty)
//   full, q    : occupancy flag and stored word
module hold_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] d,
    output logic             full,
    output logic [WIDTH-1:0] q
);
    logic             full_d, full_q;
    logic [WIDTH-1:0] q_d, q_q;

    // wr and rd never coincide (wr needs empty, rd needs full); wr wins anyway.
    always_comb begin
        full_d = full_q;
        q_d    = q_q;
        if (rd) full_d = 1'b0;
        if (wr) begin
            full_d = 1'b1;
            q_d    = d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            q_q    <= '0;
        end else begin
            full_q <= full_d;
            q_q    <= q_d;
        end
    end

    assign full = full_q;
    assign q    = q_q;
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the 101 sequence detector.
//   clk, reset          : clock, asynchronous active-low reset
//   din, din_valid      : parallel word handshake input
//   din_ready           : high while the holding register is empty
//   out, out_valid      : serial bit (registered) and its qualifier
//   busy                : shifting or holding a word
// A word accepted while idle goes straight into the shifter; a word accepted
// while shifting waits in hold_reg and is loaded on the last-bit edge, so
// consecutive words stream without gaps.
module bit_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy
);
    localparam int             CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

    state_e           state_d, state_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic [WIDTH-1:0] sh_d, sh_q;
    logic [WIDTH-1:0] sh_nxt;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full, hold_wr, hold_rd;
    logic             accept;

    hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk   (clk),
        .reset (reset),
        .wr    (hold_wr),
        .rd    (hold_rd),
        .d     (din),
        .full  (hold_full),
        .q     (hold_q)
    );

    // Zeros are shifted in behind the data, and the shifter is cleared on the
    // way back to idle, so the line rests at 0 straight from the flop.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign sh_nxt = {sh_q[WIDTH-2:0], 1'b0};
            assign out    = sh_q[WIDTH-1];
        end else begin : g_lsb
            assign sh_nxt = {1'b0, sh_q[WIDTH-1:1]};
            assign out    = sh_q[0];
        end
    endgenerate

    assign din_ready = ~hold_full;
    assign accept    = din_valid & ~hold_full;
    assign out_valid = (state_q == S_SHIFT);
    assign busy      = (state_q == S_SHIFT) | hold_full;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        hold_wr = 1'b0;
        hold_rd = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sh_d    = din;
                    cnt_d   = CNT_MAX;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    sh_d    = sh_nxt;
                    cnt_d   = cnt_q - CW'(1);
                    hold_wr = accept;
                end else if (hold_full) begin
                    // ready is low here, so no new word can race the held one
                    sh_d    = hold_q;
                    hold_rd = 1'b1;
                    cnt_d   = CNT_MAX;
                end else if (accept) begin
                    sh_d    = din;
                    cnt_d   = CNT_MAX;
                end else begin
                    sh_d    = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                sh_d    = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Directed, table-driven bench for bit_serializer (MSB-first and LSB-first
// instances). Each record holds the inputs for one cycle and the outputs
// expected during that same cycle.
module tb_bit_serializer;
    logic       clk;
    logic       reset;
    logic [7:0] din, din_l;
    logic       din_valid, din_valid_l;
    logic       din_ready, din_ready_l;
    logic       out, out_l;
    logic       out_valid, out_valid_l;
    logic       busy, busy_l;

    int checks   = 0;
    int failures = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .din       (din_l),
        .din_valid (din_valid_l),
        .din_ready (din_ready_l),
        .out       (out_l),
        .out_valid (out_valid_l),
        .busy      (busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [7:0] d;
        logic       rdy;
        logic       o;
        logic       ov;
        logic       bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic v, logic [7:0] d, logic r, logic o, logic ov, logic b);
        vec_t e;
        e.vld = v; e.d = d; e.rdy = r; e.o = o; e.ov = ov; e.bsy = b;
        tbl.push_back(e);
    endfunction

    task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        logic [2:0] hist;
        int det_cnt, det_cyc;

        reset = 1'b0; din = '0; din_valid = 1'b0; din_l = '0; din_valid_l = 1'b0;
        #2;
        chk("rst_out", 0, {7'd0, out}, 8'd0);
        chk("rst_out_valid", 0, {7'd0, out_valid}, 8'd0);
        chk("rst_busy", 0, {7'd0, busy}, 8'd0);
        chk("rst_ready", 0, {7'd0, din_ready}, 8'd1);
        chk("rst_lsb_ready", 0, {7'd0, din_ready_l}, 8'd1);
        step();
        step();
        reset = 1'b1;
        step();

        // single word 1010_0000
        add(1, 8'hA0, 1, 0, 0, 0);
        pat = 8'b1010_0000;
        for (int i = 7; i >= 0; i--) add(0, 8'h00, 1, pat[i], 1, 1);
        add(0, 8'h00, 1, 0, 0, 0);
        // back-to-back A5 then 3C through the holding register
        add(1, 8'hA5, 1, 0, 0, 0);
        add(1, 8'h3C, 1, 1, 1, 1);
        pat = 8'hA5;
        for (int i = 6; i >= 0; i--) add(0, 8'h00, 0, pat[i], 1, 1);
        pat = 8'h3C;
        for (int i = 7; i >= 0; i--) add(0, 8'h00, 1, pat[i], 1, 1);
        add(0, 8'h00, 1, 0, 0, 0);
        // direct load of FF on the last-bit edge of 00
        add(1, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 8'h00, 1, 0, 1, 1);
        add(1, 8'hFF, 1, 0, 1, 1);
        for (int i = 0; i < 8; i++) add(0, 8'h00, 1, 1, 1, 1);
        add(0, 8'h00, 1, 0, 0, 0);
        // continuous pressure 81, 42, 24, each held until accepted
        add(1, 8'h81, 1, 0, 0, 0);
        add(1, 8'h42, 1, 1, 1, 1);
        pat = 8'h81;
        for (int i = 6; i >= 0; i--) add(1, 8'h42, 0, pat[i], 1, 1);
        add(1, 8'h24, 1, 0, 1, 1);
        pat = 8'h42;
        for (int i = 6; i >= 0; i--) add(0, 8'h00, 0, pat[i], 1, 1);
        pat = 8'h24;
        for (int i = 7; i >= 0; i--) add(0, 8'h00, 1, pat[i], 1, 1);
        add(0, 8'h00, 1, 0, 0, 0);

        hist = 3'b000; det_cnt = 0; det_cyc = -1;
        for (int k = 0; k < tbl.size(); k++) begin
            din_valid = tbl[k].vld;
            din       = tbl[k].d;
            chk("ready", k, {7'd0, din_ready}, {7'd0, tbl[k].rdy});
            chk("out", k, {7'd0, out}, {7'd0, tbl[k].o});
            chk("out_valid", k, {7'd0, out_valid}, {7'd0, tbl[k].ov});
            chk("busy", k, {7'd0, busy}, {7'd0, tbl[k].bsy});
            if (k < 10) begin
                hist = {hist[1:0], out};
                if (hist == 3'b101) begin
                    det_cnt++;
                    det_cyc = k;
                end
            end
            step();
        end
        din_valid = 1'b0;
        chk("det_count", 0, 8'(det_cnt), 8'd1);
        chk("det_cycle", 0, 8'(det_cyc), 8'd3);

        // reset mid-word: E7 shifting, 55 sitting in the holding register
        din_valid = 1'b1; din = 8'hE7;
        step();
        din = 8'h55;
        step();
        din_valid = 1'b0;
        chk("mid_hold_ready", 0, {7'd0, din_ready}, 8'd0);
        step();
        chk("mid_bit3", 0, {7'd0, out}, 8'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_out", 0, {7'd0, out}, 8'd0);
        chk("mid_out_valid", 0, {7'd0, out_valid}, 8'd0);
        chk("mid_ready", 0, {7'd0, din_ready}, 8'd1);
        chk("mid_busy", 0, {7'd0, busy}, 8'd0);
        step();
        reset = 1'b1;
        step();
        din_valid = 1'b1; din = 8'h80;
        step();
        din_valid = 1'b0;
        pat = 8'h80;
        for (int i = 7; i >= 0; i--) begin
            chk("post_rst_out", i, {7'd0, out}, {7'd0, pat[i]});
            chk("post_rst_ov", i, {7'd0, out_valid}, 8'd1);
            step();
        end
        chk("post_rst_idle_ov", 0, {7'd0, out_valid}, 8'd0);
        chk("post_rst_idle_busy", 0, {7'd0, busy}, 8'd0);

        // LSB-first instance
        din_valid_l = 1'b1; din_l = 8'h01;
        step();
        din_valid_l = 1'b0;
        pat = 8'h80;  // expected stream in time order: 1 then seven 0s
        for (int i = 7; i >= 0; i--) begin
            chk("lsb_out", i, {7'd0, out_l}, {7'd0, pat[i]});
            chk("lsb_ov", i, {7'd0, out_valid_l}, 8'd1);
            step();
        end
        chk("lsb_idle_ov", 0, {7'd0, out_valid_l}, 8'd0);
        chk("lsb_idle_out", 0, {7'd0, out_l}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
